one_to_four_demux: RTL and testbench

ONE_TO_FOUR_DEMUX -- requirements
Module: one_to_four_demux

---
 rtl/one_to_four_demux_pkg.sv | 17 +
 rtl/one_to_four_demux_if.sv | 27 ++
 rtl/one_to_four_demux_chan_reg.sv | 33 +++
 rtl/one_to_four_demux.sv | 66 ++++++
 tb/tb_one_to_four_demux.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/one_to_four_demux_pkg.sv
// Shared constants and types for the 1-to-4 demux: channel count, pointer width, mode encodings.
package one_to_four_demux_pkg;

    localparam int unsigned CHAN_NUM = 4;
    localparam int unsigned PTR_W    = 2;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // One-hot channel mask for a channel index.
    function automatic logic [CHAN_NUM-1:0] chan_onehot(input logic [PTR_W-1:0] idx);
        return CHAN_NUM'(1) << idx;
    endfunction

endpackage

// File: rtl/one_to_four_demux_if.sv
// Input word handshake plus four output channels of the 1-to-4 demux.
interface one_to_four_demux_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [1:0]       sel;
    logic             mode;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       cur_sel;

    modport master (
        output din, din_valid, sel, mode, out_ready,
        input  din_ready, out1, out2, out3, out4, out_valid, cur_sel
    );

    modport slave (
        input  din, din_valid, sel, mode, out_ready,
        output din_ready, out1, out2, out3, out4, out_valid, cur_sel
    );
endinterface

// File: rtl/one_to_four_demux_chan_reg.sv
// One-entry holding register for a single demux output channel.
module demux_chan_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A load wins over a drain in the same cycle; data is held after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_din;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/one_to_four_demux.sv
// 1-to-4 demux: routes each accepted word to a channel chosen by sel (fixed) or a round-robin pointer.
module one_to_four_demux
    import one_to_four_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic                clk,
    input logic                rst_n,
    one_to_four_demux_if.slave bus
);

    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    w_rr_ptr_nxt;
    logic [PTR_W-1:0]    w_cur_sel;
    logic                w_rr_mode;
    logic                w_din_ready;
    logic                w_accept;
    logic [CHAN_NUM-1:0] w_load;
    logic [CHAN_NUM-1:0] w_valid;
    logic [WIDTH-1:0]    w_data [CHAN_NUM];

    assign w_rr_mode   = (mode_e'(bus.mode) == MODE_RR);
    assign w_cur_sel   = w_rr_mode ? r_rr_ptr : bus.sel;
    assign w_din_ready = ~w_valid[w_cur_sel] | bus.out_ready[w_cur_sel];
    assign w_accept    = bus.din_valid & w_din_ready;
    assign w_load      = w_accept ? chan_onehot(w_cur_sel) : '0;

    // Pointer only moves on a round-robin accept; mode switches leave it untouched.
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_accept && w_rr_mode) begin
            w_rr_ptr_nxt = r_rr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    for (genvar g = 0; g < CHAN_NUM; g++) begin : g_chan
        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_din   (bus.din),
            .i_ready (bus.out_ready[g]),
            .o_data  (w_data[g]),
            .o_valid (w_valid[g])
        );
    end

    assign bus.out1      = w_data[0];
    assign bus.out2      = w_data[1];
    assign bus.out3      = w_data[2];
    assign bus.out4      = w_data[3];
    assign bus.out_valid = w_valid;
    assign bus.cur_sel   = w_cur_sel;
    assign bus.din_ready = w_din_ready;

endmodule

// File: tb/tb_one_to_four_demux.sv
// Self-checking bench for one_to_four_demux: directed scenarios plus randomized traffic vs. a queue-style model.
module tb_one_to_four_demux;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_tests;
    int   n_fail;

    one_to_four_demux_if #(.WIDTH(W)) bus ();

    one_to_four_demux #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] t_out [4];
    always_comb begin
        t_out[0] = bus.out1;
        t_out[1] = bus.out2;
        t_out[2] = bus.out3;
        t_out[3] = bus.out4;
    end

    // Reference model: each channel is a one-slot mailbox; pointer counts round-robin accepts mod 4.
    logic [W-1:0] m_data [4];
    logic [3:0]   m_valid;
    int           m_ptr;

    always @(posedge clk or negedge rst_n) begin
        int  tgt;
        bit  room;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_data[i] = '0;
            m_valid = '0;
            m_ptr   = 0;
        end else begin
            tgt  = bus.mode ? m_ptr : int'(bus.sel);
            room = !m_valid[tgt] || bus.out_ready[tgt];
            for (int i = 0; i < 4; i++)
                if (m_valid[i] && bus.out_ready[i]) m_valid[i] = 1'b0;
            if (bus.din_valid && room) begin
                m_data[tgt]  = bus.din;
                m_valid[tgt] = 1'b1;
                if (bus.mode) m_ptr = (m_ptr + 1) % 4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int  es;
        bit  erdy;
        if (chk_en) begin
            es   = bus.mode ? m_ptr : int'(bus.sel);
            erdy = !m_valid[es] || bus.out_ready[es];
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            for (int i = 0; i < 4; i++) chk("out_data", 32'(t_out[i]), 32'(m_data[i]));
            chk("cur_sel", 32'(bus.cur_sel), 32'(es));
            chk("din_ready", 32'(bus.din_ready), 32'(erdy));
        end
    end

    task automatic drive(input logic dv, input logic [W-1:0] d, input logic [1:0] s,
                         input logic m, input logic [3:0] ordy);
        bus.din_valid = dv;
        bus.din       = d;
        bus.sel       = s;
        bus.mode      = m;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] vals [4];
        logic [W-1:0] rr_vals [5];
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b1;
        rst_n   = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0, 4'b0000);
        @(negedge clk); #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);

        // First word accepted on the first edge after reset release.
        rst_n = 1'b1;
        drive(1'b1, 8'h5A, 2'd0, 1'b0, 4'b0000);
        tick();
        chk("first_valid", 32'(bus.out_valid), 32'b0001);
        chk("first_data", 32'(bus.out1), 32'h5A);

        // Fixed routing, one-hot valid one cycle after each accept.
        vals[0] = 8'd1; vals[1] = 8'd0; vals[2] = 8'd1; vals[3] = 8'd1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, vals[k], 2'(k), 1'b0, 4'b1111);
            tick();
            chk("fixed_valid", 32'(bus.out_valid), 32'(4'b0001 << k));
            chk("fixed_data", 32'(t_out[k]), 32'(vals[k]));
        end
        chk("fixed_out1", 32'(bus.out1), 32'd1);
        chk("fixed_out2", 32'(bus.out2), 32'd0);
        drive(1'b0, '0, 2'd0, 1'b0, 4'b1111);
        tick();
        chk("fixed_drained", 32'(bus.out_valid), 32'h0);
        chk("fixed_held4", 32'(bus.out4), 32'd1);

        // Backpressure on channel 3.
        drive(1'b1, 8'd1, 2'd2, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 8'd0, 2'd2, 1'b0, 4'b0000);
        chk("bp_ready_low", 32'(bus.din_ready), 32'd0);
        tick();
        chk("bp_hold_data", 32'(bus.out3), 32'd1);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'b0100);
        drive(1'b1, 8'd0, 2'd2, 1'b0, 4'b0100);
        chk("bp_ready_high", 32'(bus.din_ready), 32'd1);
        tick();
        chk("bp_second", 32'(bus.out3), 32'd0);
        chk("bp_second_v", 32'(bus.out_valid), 32'b0100);
        drive(1'b0, 8'd0, 2'd2, 1'b0, 4'b0100);
        tick();
        chk("bp_drain", 32'(bus.out_valid), 32'h0);

        // Round-robin from pointer 0, wrapping 3 -> 0.
        rr_vals[0] = 8'd1; rr_vals[1] = 8'd0; rr_vals[2] = 8'd1; rr_vals[3] = 8'd0; rr_vals[4] = 8'd1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rr_vals[k], 2'd0, 1'b1, 4'b1111);
            chk("rr_cur_sel", 32'(bus.cur_sel), 32'(k % 4));
            tick();
            chk("rr_valid", 32'(bus.out_valid), 32'(4'b0001 << (k % 4)));
        end
        chk("rr_out1", 32'(bus.out1), 32'd1);
        drive(1'b0, '0, 2'd0, 1'b1, 4'b1111);
        chk("rr_ptr_1", 32'(bus.cur_sel), 32'd1);

        // Build out_valid = 1011 then reset asynchronously mid-cycle.
        drive(1'b1, 8'h11, 2'd0, 1'b0, 4'b0000); tick();
        drive(1'b1, 8'h22, 2'd1, 1'b0, 4'b0000); tick();
        drive(1'b1, 8'h44, 2'd3, 1'b0, 4'b0000); tick();
        drive(1'b0, '0, 2'd0, 1'b1, 4'b0000);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_out4", 32'(bus.out4), 32'h0);
        chk("async_rst_ptr", 32'(bus.cur_sel), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Mode switch keeps the pointer: 2 RR, 3 fixed, then RR lands on out3.
        for (int k = 0; k < 2; k++) begin drive(1'b1, 8'(k), 2'd0, 1'b1, 4'b1111); tick(); end
        for (int k = 0; k < 3; k++) begin drive(1'b1, 8'(k), 2'd0, 1'b0, 4'b1111); tick(); end
        drive(1'b1, 8'hC3, 2'd0, 1'b1, 4'b1111);
        chk("ms_cur_sel", 32'(bus.cur_sel), 32'd2);
        tick();
        chk("ms_valid", 32'(bus.out_valid), 32'b0100);
        chk("ms_out3", 32'(bus.out3), 32'hC3);

        // Simultaneous drain and load on channel 2.
        drive(1'b1, 8'hAA, 2'd1, 1'b0, 4'b0000); tick();
        drive(1'b1, 8'h55, 2'd1, 1'b0, 4'b0010); tick();
        chk("sim_valid", 32'(bus.out_valid[1]), 32'd1);
        chk("sim_out2", 32'(bus.out2), 32'h55);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), 2'($urandom), 1'($urandom),
                  4'($urandom));
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else                             rst_n = 1'b1;
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
